// File: rtl/z80_mem_arbiter.sv
// Arbitrates one synchronous single-port RAM between Z80 memory cycles and a video fetch port.
// The CPU is stalled with cpu_wait_n until its own access completes; ties alternate between sides.
module z80_mem_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_mreq_n,
  input  logic              cpu_rd_n,
  input  logic              cpu_wr_n,
  input  logic              cpu_rfsh_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_dout,
  output logic [7:0]        cpu_din,
  output logic              cpu_wait_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [7:0]        vid_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam int unsigned CNT_W    = 2;
  localparam logic        LAST_CPU = 1'b1;
  localparam logic        LAST_VID = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CPU_RD,
    S_CPU_WR,
    S_VID_RD,
    S_CPU_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;
  logic [7:0]         cpu_din_q, cpu_din_d;
  logic [7:0]         vid_data_q, vid_data_d;
  logic               vid_ack_q, vid_ack_d;
  logic               mem_en_q, mem_en_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [7:0]         mem_wdata_q, mem_wdata_d;

  logic cpu_req;
  logic vid_go;
  logic rd_cap;
  logic cpu_done_c;

  assign cpu_req = ~cpu_mreq_n & cpu_rfsh_n & (cpu_rd_n ^ cpu_wr_n);
  // The requester still holds vid_req during its ack cycle; do not treat that as a new fetch.
  assign vid_go  = vid_req & ~vid_ack_q;
  assign rd_cap  = (cnt_q == CNT_W'(MEM_LAT));

  assign cpu_done_c = ((state_q == S_CPU_RD) && rd_cap) || (state_q == S_CPU_WR);
  assign cpu_wait_n = reset | ~(cpu_req & (state_q != S_CPU_DONE) & ~cpu_done_c);

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    cpu_din_d   = cpu_din_q;
    vid_data_d  = vid_data_q;
    vid_ack_d   = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (cpu_req && (!vid_go || (last_q == LAST_VID))) begin
          last_d     = LAST_CPU;
          cnt_d      = '0;
          mem_en_d   = 1'b1;
          mem_addr_d = cpu_addr;
          if (!cpu_wr_n) begin
            state_d     = S_CPU_WR;
            mem_we_d    = 1'b1;
            mem_wdata_d = cpu_dout;
          end else begin
            state_d = S_CPU_RD;
          end
        end else if (vid_go) begin
          last_d     = LAST_VID;
          cnt_d      = '0;
          mem_en_d   = 1'b1;
          mem_addr_d = vid_addr;
          state_d    = S_VID_RD;
        end
      end
      S_CPU_RD: begin
        if (rd_cap) begin
          cpu_din_d = mem_rdata;
          cnt_d     = '0;
          state_d   = cpu_req ? S_CPU_DONE : S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CPU_WR: begin
        state_d = cpu_req ? S_CPU_DONE : S_IDLE;
      end
      S_VID_RD: begin
        if (rd_cap) begin
          vid_data_d = mem_rdata;
          vid_ack_d  = 1'b1;
          cnt_d      = '0;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CPU_DONE: begin
        if (!cpu_req) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_q      <= LAST_VID;
      cpu_din_q   <= 8'h00;
      vid_data_q  <= 8'h00;
      vid_ack_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      cpu_din_q   <= cpu_din_d;
      vid_data_q  <= vid_data_d;
      vid_ack_q   <= vid_ack_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign cpu_din   = cpu_din_q;
  assign vid_data  = vid_data_q;
  assign vid_ack   = vid_ack_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_z80_mem_arbiter.sv
// Directed bench for z80_mem_arbiter: cycle table for CPU traffic, hand sequences for
// arbitration ties, CPU/video collision and reset during an access.
module tb_z80_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_rfsh_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        cpu_wait_n;
  logic        vid_req;
  logic [15:0] vid_addr;
  logic        vid_ack;
  logic [7:0]  vid_data;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int checks = 0;
  int errors = 0;

  z80_mem_arbiter #(.ADDR_W(16), .MEM_LAT(1)) dut (
    .clk        (clk),
    .reset      (rst),
    .cpu_mreq_n (cpu_mreq_n),
    .cpu_rd_n   (cpu_rd_n),
    .cpu_wr_n   (cpu_wr_n),
    .cpu_rfsh_n (cpu_rfsh_n),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .cpu_din    (cpu_din),
    .cpu_wait_n (cpu_wait_n),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_ack    (vid_ack),
    .vid_data   (vid_data),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM, one cycle read latency
  logic [7:0] ram [0:65535];
  logic       loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      ram[16'h1234] <= 8'hA5;
      mem_rdata     <= 8'h00;
      loaded        <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic strobes_idle();
    cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1; cpu_rfsh_n = 1'b1;
  endtask

  task automatic cpu_drive(input logic wr, input logic [15:0] a, input logic [7:0] d);
    cpu_mreq_n = 1'b0; cpu_rd_n = wr; cpu_wr_n = ~wr; cpu_rfsh_n = 1'b1;
    cpu_addr = a; cpu_dout = d;
  endtask

  task automatic cpu_access(input logic wr, input logic [15:0] a, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    cpu_drive(wr, a, d);
    for (int k = 0; k < 20 && !ok; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (cpu_wait_n) ok = 1'b1;
    end
    check("cpu_access completes", 32'(ok), 32'd1);
    @(negedge clk);
    strobes_idle();
    @(negedge clk);
  endtask

  logic [15:0] grants [$];
  int          ack_cnt;
  logic [7:0]  vdata_seen;

  // Both sides request in the same cycle; record the order of RAM issues
  task automatic run_tie(input logic [15:0] ca, input logic [15:0] va);
    bit cpu_done, ack_seen;
    cpu_done = 1'b0; ack_seen = 1'b0; ack_cnt = 0; vdata_seen = 8'h00;
    grants.delete();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) begin
        cpu_drive(1'b0, ca, 8'h00);
        vid_req = 1'b1; vid_addr = va;
      end
      if (cpu_done) strobes_idle();
      if (ack_seen) vid_req = 1'b0;
      #1;
      if (mem_en) grants.push_back(mem_addr);
      if (vid_ack) begin ack_cnt++; vdata_seen = vid_data; ack_seen = 1'b1; end
      if (!cpu_mreq_n && cpu_wait_n) cpu_done = 1'b1;
    end
  endtask

  typedef struct {
    logic        mreq_n, rd_n, wr_n, rfsh_n;
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        en, we;
    logic [15:0] maddr;
    logic [7:0]  wdata;
    logic        wait_n;
    logic [7:0]  din;
  } vec_t;

  vec_t vecs [30];

  initial begin
    logic [15:0] g0, g1;
    int          lowc, pulses;
    bit          done, ack_seen;

    // {mreq_n,rd_n,wr_n,rfsh_n,addr,dout} -> {en,we,maddr,wdata,wait_n,din}
    vecs[0]  = '{1'b1,1'b1,1'b1,1'b1,16'h0000,8'h00, 1'b0,1'b0,16'h0000,8'h00,1'b1,8'h00};
    vecs[1]  = '{1'b0,1'b0,1'b1,1'b1,16'h1234,8'h00, 1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00};
    vecs[2]  = '{1'b0,1'b0,1'b1,1'b1,16'h1234,8'h00, 1'b1,1'b0,16'h1234,8'h00,1'b0,8'h00};
    vecs[3]  = '{1'b0,1'b0,1'b1,1'b1,16'h1234,8'h00, 1'b0,1'b0,16'h1234,8'h00,1'b1,8'h00};
    vecs[4]  = '{1'b0,1'b0,1'b1,1'b1,16'h1234,8'h00, 1'b0,1'b0,16'h1234,8'h00,1'b1,8'hA5};
    vecs[5]  = '{1'b0,1'b0,1'b1,1'b1,16'h1234,8'h00, 1'b0,1'b0,16'h1234,8'h00,1'b1,8'hA5};
    vecs[6]  = '{1'b1,1'b1,1'b1,1'b1,16'h0000,8'h00, 1'b0,1'b0,16'h1234,8'h00,1'b1,8'hA5};
    vecs[7]  = '{1'b1,1'b1,1'b1,1'b1,16'h0000,8'h00, 1'b0,1'b0,16'h1234,8'h00,1'b1,8'hA5};
    vecs[8]  = '{1'b0,1'b1,1'b0,1'b1,16'h0100,8'h3C, 1'b0,1'b0,16'h1234,8'h00,1'b0,8'hA5};
    vecs[9]  = '{1'b0,1'b1,1'b0,1'b1,16'h0100,8'h3C, 1'b1,1'b1,16'h0100,8'h3C,1'b1,8'hA5};
    vecs[10] = '{1'b0,1'b1,1'b0,1'b1,16'h0100,8'h3C, 1'b0,1'b0,16'h0100,8'h3C,1'b1,8'hA5};
    vecs[11] = '{1'b1,1'b1,1'b1,1'b1,16'h0000,8'h00, 1'b0,1'b0,16'h0100,8'h3C,1'b1,8'hA5};
    vecs[12] = '{1'b0,1'b0,1'b1,1'b1,16'h0100,8'h00, 1'b0,1'b0,16'h0100,8'h3C,1'b0,8'hA5};
    vecs[13] = '{1'b0,1'b0,1'b1,1'b1,16'h0100,8'h00, 1'b1,1'b0,16'h0100,8'h3C,1'b0,8'hA5};
    vecs[14] = '{1'b0,1'b0,1'b1,1'b1,16'h0100,8'h00, 1'b0,1'b0,16'h0100,8'h3C,1'b1,8'hA5};
    vecs[15] = '{1'b1,1'b1,1'b1,1'b1,16'h0000,8'h00, 1'b0,1'b0,16'h0100,8'h3C,1'b1,8'h3C};
    vecs[16] = '{1'b1,1'b1,1'b1,1'b1,16'h0000,8'h00, 1'b0,1'b0,16'h0100,8'h3C,1'b1,8'h3C};
    vecs[17] = '{1'b0,1'b1,1'b1,1'b0,16'h0200,8'h00, 1'b0,1'b0,16'h0100,8'h3C,1'b1,8'h3C};
    vecs[18] = '{1'b0,1'b1,1'b1,1'b0,16'h0200,8'h00, 1'b0,1'b0,16'h0100,8'h3C,1'b1,8'h3C};
    vecs[19] = '{1'b0,1'b0,1'b0,1'b1,16'h0200,8'h00, 1'b0,1'b0,16'h0100,8'h3C,1'b1,8'h3C};
    vecs[20] = '{1'b0,1'b0,1'b0,1'b1,16'h0200,8'h00, 1'b0,1'b0,16'h0100,8'h3C,1'b1,8'h3C};
    vecs[21] = '{1'b1,1'b1,1'b1,1'b1,16'h0000,8'h00, 1'b0,1'b0,16'h0100,8'h3C,1'b1,8'h3C};
    vecs[22] = '{1'b0,1'b1,1'b0,1'b1,16'h0300,8'h77, 1'b0,1'b0,16'h0100,8'h3C,1'b0,8'h3C};
    vecs[23] = '{1'b1,1'b1,1'b1,1'b1,16'h0000,8'h00, 1'b1,1'b1,16'h0300,8'h77,1'b1,8'h3C};
    vecs[24] = '{1'b1,1'b1,1'b1,1'b1,16'h0000,8'h00, 1'b0,1'b0,16'h0300,8'h77,1'b1,8'h3C};
    vecs[25] = '{1'b0,1'b0,1'b1,1'b1,16'h0300,8'h00, 1'b0,1'b0,16'h0300,8'h77,1'b0,8'h3C};
    vecs[26] = '{1'b0,1'b0,1'b1,1'b1,16'h0300,8'h00, 1'b1,1'b0,16'h0300,8'h77,1'b0,8'h3C};
    vecs[27] = '{1'b1,1'b1,1'b1,1'b1,16'h0000,8'h00, 1'b0,1'b0,16'h0300,8'h77,1'b1,8'h3C};
    vecs[28] = '{1'b1,1'b1,1'b1,1'b1,16'h0000,8'h00, 1'b0,1'b0,16'h0300,8'h77,1'b1,8'h77};
    vecs[29] = '{1'b1,1'b1,1'b1,1'b1,16'h0000,8'h00, 1'b0,1'b0,16'h0300,8'h77,1'b1,8'h77};

    rst = 1'b1;
    strobes_idle();
    cpu_addr = 16'h0000; cpu_dout = 8'h00;
    vid_req = 1'b0; vid_addr = 16'h0000;
    repeat (2) @(negedge clk);
    #1;
    check("reset mem_en", 32'(mem_en), 32'd0);
    check("reset mem_we", 32'(mem_we), 32'd0);
    check("reset mem_addr", 32'(mem_addr), 32'd0);
    check("reset cpu_wait_n", 32'(cpu_wait_n), 32'd1);
    check("reset vid_ack", 32'(vid_ack), 32'd0);
    check("reset cpu_din", 32'(cpu_din), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // CPU read, write, readback, refresh, invalid strobes, strobe released mid-access
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      cpu_mreq_n = vecs[i].mreq_n; cpu_rd_n = vecs[i].rd_n;
      cpu_wr_n = vecs[i].wr_n; cpu_rfsh_n = vecs[i].rfsh_n;
      cpu_addr = vecs[i].addr; cpu_dout = vecs[i].dout;
      #1;
      check($sformatf("vec%0d mem_en", i), 32'(mem_en), 32'(vecs[i].en));
      check($sformatf("vec%0d mem_we", i), 32'(mem_we), 32'(vecs[i].we));
      check($sformatf("vec%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].maddr));
      check($sformatf("vec%0d mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].wdata));
      check($sformatf("vec%0d cpu_wait_n", i), 32'(cpu_wait_n), 32'(vecs[i].wait_n));
      check($sformatf("vec%0d cpu_din", i), 32'(cpu_din), 32'(vecs[i].din));
    end

    // First tie after reset goes to the CPU, then video
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    run_tie(16'h1234, 16'h0100);
    g0 = (grants.size() > 0) ? grants[0] : 16'hFFFF;
    g1 = (grants.size() > 1) ? grants[1] : 16'hFFFF;
    check("tie1 grant count", 32'(grants.size()), 32'd2);
    check("tie1 first grant", 32'(g0), 32'h1234);
    check("tie1 second grant", 32'(g1), 32'h0100);
    check("tie1 vid_ack pulses", 32'(ack_cnt), 32'd1);
    check("tie1 vid_data", 32'(vdata_seen), 32'h3C);
    check("tie1 cpu_din", 32'(cpu_din), 32'hA5);

    // A CPU-only grant leaves last=CPU, so the next tie goes to video
    cpu_access(1'b1, 16'h0500, 8'h11);
    run_tie(16'h0100, 16'h0300);
    g0 = (grants.size() > 0) ? grants[0] : 16'hFFFF;
    g1 = (grants.size() > 1) ? grants[1] : 16'hFFFF;
    check("tie2 grant count", 32'(grants.size()), 32'd2);
    check("tie2 first grant", 32'(g0), 32'h0300);
    check("tie2 second grant", 32'(g1), 32'h0100);
    check("tie2 vid_ack pulses", 32'(ack_cnt), 32'd1);
    check("tie2 vid_data", 32'(vdata_seen), 32'h77);
    check("tie2 cpu_din", 32'(cpu_din), 32'h3C);

    // CPU read arrives while a video fetch is in flight
    @(negedge clk);
    vid_req = 1'b1; vid_addr = 16'h1234;
    #1;
    check("collide wait idle", 32'(cpu_wait_n), 32'd1);
    @(negedge clk); #1;
    check("collide vid issue en", 32'(mem_en), 32'd1);
    check("collide vid issue addr", 32'(mem_addr), 32'h1234);
    @(negedge clk);
    cpu_drive(1'b0, 16'h0100, 8'h00);
    lowc = 0; done = 1'b0; ack_seen = 1'b0; ack_cnt = 0; vdata_seen = 8'h00;
    for (int k = 0; k < 20 && !done; k++) begin
      if (k > 0) @(negedge clk);
      if (ack_seen) vid_req = 1'b0;
      #1;
      if (vid_ack) begin ack_cnt++; vdata_seen = vid_data; ack_seen = 1'b1; end
      if (cpu_wait_n) done = 1'b1;
      else lowc++;
    end
    check("collide completes", 32'(done), 32'd1);
    check("collide wait cycles", 32'(lowc), 32'd3);
    check("collide vid_data", 32'(vdata_seen), 32'hA5);
    @(negedge clk);
    strobes_idle(); vid_req = 1'b0;
    #1;
    check("collide cpu_din", 32'(cpu_din), 32'h3C);
    check("collide ack count", 32'(ack_cnt), 32'd1);

    // Reset during CPU read latency, strobe held through release
    @(negedge clk);
    cpu_drive(1'b0, 16'h1234, 8'h00);
    @(negedge clk); #1;
    check("rstrd issue en", 32'(mem_en), 32'd1);
    rst = 1'b1;
    #1;
    check("rstrd mem_en", 32'(mem_en), 32'd0);
    check("rstrd mem_addr", 32'(mem_addr), 32'd0);
    check("rstrd cpu_din", 32'(cpu_din), 32'd0);
    check("rstrd vid_data", 32'(vid_data), 32'd0);
    check("rstrd mem_wdata", 32'(mem_wdata), 32'd0);
    check("rstrd cpu_wait_n", 32'(cpu_wait_n), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstrd fresh wait", 32'(cpu_wait_n), 32'd0);
    pulses = 0; done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk); #1;
      if (mem_en) pulses++;
      if (cpu_wait_n) done = 1'b1;
    end
    check("rstrd completes", 32'(done), 32'd1);
    repeat (2) begin
      @(negedge clk); #1;
      if (mem_en) pulses++;
    end
    check("rstrd single issue", 32'(pulses), 32'd1);
    check("rstrd cpu_din", 32'(cpu_din), 32'hA5);
    @(negedge clk);
    strobes_idle();

    // Reset between write decision and issue: the write must never reach RAM
    @(negedge clk);
    cpu_drive(1'b1, 16'h0400, 8'h99);
    #1;
    check("rstwr wait low", 32'(cpu_wait_n), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    strobes_idle();
    rst = 1'b0;
    pulses = 0;
    repeat (3) begin
      @(negedge clk); #1;
      if (mem_we) pulses++;
    end
    check("rstwr no write", 32'(pulses), 32'd0);
    check("rstwr mem_wdata", 32'(mem_wdata), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
